if_stage: RTL and testbench

// - Fetch stage: owns the PC and issues instruction-SRAM reads; delivers {adef, pc, inst} to ID.
// - Consumes the WB redirect (expt_clear/expt_refresh_pc) and the ID branch bus.
// - One request in flight max; sync SRAM returns rdata the cycle after the request.
// - Holds rdata in a local buffer while ID stalls.

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage.sv | 105 ++++++++++
 tb/tb_if_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, reset address and the IF->ID bus layout for the fetch stage.
package if_stage_pkg;

  localparam int unsigned FS_TO_DS_BUS_WD = 65;
  localparam int unsigned IF_BR_BUS_WD    = 33;
  localparam logic [31:0] IF_RESET_PC     = 32'h1c00_0000;

  // Field offsets within fs_to_ds_bus.
  localparam int unsigned FS_INST_LSB = 0;
  localparam int unsigned FS_PC_LSB   = 32;
  localparam int unsigned FS_ADEF_BIT = 64;

  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

endpackage

// File: rtl/if_stage.sv
// Fetch stage: owns the PC, issues one instruction-SRAM read per accepted slot,
// and holds returned data in a one-entry buffer while ID is stalled.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter int unsigned BR_BUS_WD = IF_BR_BUS_WD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  input  logic                       expt_clear,
  input  logic [31:0]                expt_refresh_pc,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  logic [31:0] fs_pc_q, fs_pc_d;
  logic        fs_valid_q, fs_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic        redirect;
  logic        fs_allowin;
  logic        buf_capture;
  logic [31:0] nextpc;
  logic        fs_adef;
  logic [31:0] fs_inst;
  fs_to_ds_t   bus;

  assign br_taken  = br_bus[BR_BUS_WD-1];
  assign br_target = br_bus[31:0];
  assign redirect  = br_taken | expt_clear;

  // Exception flush outranks a same-cycle branch.
  always_comb begin
    nextpc = fs_pc_q + 32'd4;
    if (expt_clear) begin
      nextpc = expt_refresh_pc;
    end else if (br_taken) begin
      nextpc = br_target;
    end
  end

  assign fs_allowin  = ~fs_valid_q | ds_allowin | redirect;
  assign buf_capture = fs_valid_q & ~buf_valid_q & ~ds_allowin & ~redirect;

  assign inst_sram_en    = ~reset & fs_allowin;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // A misaligned PC still fetches; ID/WB raise ADEF from the flag.
  assign fs_adef = fs_valid_q & (fs_pc_q[1:0] != 2'b00);
  assign fs_inst = fs_adef       ? 32'h0      :
                   buf_valid_q   ? inst_buf_q : inst_sram_rdata;

  assign fs_to_ds_valid = fs_valid_q & ~redirect & ~reset;

  always_comb begin
    bus.adef     = fs_adef;
    bus.pc       = fs_pc_q;
    bus.inst     = fs_inst;
    fs_to_ds_bus = bus;
  end

  // Next-state: a new issue always drops any held instruction.
  always_comb begin
    fs_pc_d     = fs_pc_q;
    fs_valid_d  = fs_valid_q;
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    if (fs_allowin) begin
      fs_pc_d     = nextpc;
      fs_valid_d  = 1'b1;
      buf_valid_d = 1'b0;
    end else if (buf_capture) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_pc_q     <= RESET_PC - 32'd4;
      fs_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'h0;
    end else begin
      fs_pc_q     <= fs_pc_d;
      fs_valid_q  <= fs_valid_d;
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: address-keyed SRAM responder, an abstract
// fetch model checked every cycle, plus literal checkpoints.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ds_allowin = 1'b0;
  logic [32:0] br_bus = 33'h0;
  logic        expt_clear = 1'b0;
  logic [31:0] expt_refresh_pc = 32'h0;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  logic armed = 1'b0;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .expt_clear      (expt_clear),
    .expt_refresh_pc (expt_refresh_pc),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0008) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Sync SRAM: data for last cycle's request, garbage otherwise.
  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'($urandom());
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Abstract model: which pc ID sees, and the word memory holds there.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'h1c00_0000 - 32'd4;

  always @(negedge clk) begin
    logic        br, allow, exp_en, exp_valid, adef;
    logic [31:0] exp_addr;
    #2;
    br        = br_bus[32];
    allow     = !m_valid || ds_allowin || br || expt_clear;
    exp_en    = !reset && allow;
    exp_addr  = expt_clear ? expt_refresh_pc : (br ? br_bus[31:0] : m_pc + 32'd4);
    exp_valid = m_valid && !br && !expt_clear && !reset;
    adef      = m_pc[1:0] != 2'b00;
    if (armed) begin
      check("m_en", 65'(inst_sram_en), 65'(exp_en));
      check("m_valid", 65'(fs_to_ds_valid), 65'(exp_valid));
      check("m_we_wdata", {29'h0, inst_sram_we, inst_sram_wdata}, 65'h0);
      if (exp_en) check("m_addr", 65'(inst_sram_addr), 65'(exp_addr));
      if (exp_valid)
        check("m_bus", fs_to_ds_bus, {adef, m_pc, adef ? 32'h0 : mem_word(m_pc)});
    end
    if (reset) begin
      m_valid = 1'b0;
      m_pc    = 32'h1c00_0000 - 32'd4;
    end else if (allow) begin
      m_valid = 1'b1;
      m_pc    = exp_addr;
    end
  end

  task automatic step(input logic rst, input logic ds, input logic br,
                      input logic [31:0] tgt, input logic ex, input logic [31:0] rpc);
    @(negedge clk);
    reset           = rst;
    ds_allowin      = ds;
    br_bus          = {br, tgt};
    expt_clear      = ex;
    expt_refresh_pc = rpc;
    #1;
  endtask

  initial begin
    @(posedge clk);
    armed = 1'b1;
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("rst_en", 65'(inst_sram_en), 65'd0);
    check("rst_valid", 65'(fs_to_ds_valid), 65'd0);
    // Reset release and sequential fetch.
    step(0, 1, 0, 0, 0, 0);
    check("first_addr", 65'(inst_sram_addr), 65'h1c00_0000);
    check("first_valid", 65'(fs_to_ds_valid), 65'd0);
    step(0, 1, 0, 0, 0, 0);
    check("first_pc", {64'h0, fs_to_ds_valid} | 65'(fs_to_ds_bus[63:32]) << 1,
          65'(33'h1c00_0000) << 1 | 65'd1);
    check("second_addr", 65'(inst_sram_addr), 65'h1c00_0004);
    step(0, 1, 0, 0, 0, 0);
    // Three-cycle stall at 0x1c000008.
    step(0, 0, 0, 0, 0, 0);
    check("stall_inst0", 65'(fs_to_ds_bus[31:0]), 65'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("stall_inst2", 65'(fs_to_ds_bus[31:0]), 65'hDEAD_BEEF);
    check("stall_no_req", 65'(inst_sram_en), 65'd0);
    step(0, 1, 0, 0, 0, 0);
    check("resume_addr", 65'(inst_sram_addr), 65'h1c00_000c);
    step(0, 1, 0, 0, 0, 0);
    check("resume_pc", 65'(fs_to_ds_bus[63:32]), 65'h1c00_000c);
    // Branch at pc 0x1c000010.
    step(0, 1, 1, 32'h1c00_0100, 0, 0);
    check("br_squash", 65'(fs_to_ds_valid), 65'd0);
    check("br_addr", 65'(inst_sram_addr), 65'h1c00_0100);
    step(0, 1, 0, 0, 0, 0);
    check("br_pc", 65'(fs_to_ds_bus[63:32]), 65'h1c00_0100);
    // Exception flush beats a branch during a stall.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h1c00_0200, 1, 32'h1c00_8000);
    check("ex_addr", 65'(inst_sram_addr), 65'h1c00_8000);
    check("ex_en", 65'(inst_sram_en), 65'd1);
    check("ex_squash", 65'(fs_to_ds_valid), 65'd0);
    step(0, 1, 0, 0, 0, 0);
    check("ex_pc", 65'(fs_to_ds_bus[63:32]), 65'h1c00_8000);
    check("ex_inst", 65'(fs_to_ds_bus[31:0]), 65'(mem_word(32'h1c00_8000)));
    // Misaligned branch target.
    step(0, 1, 1, 32'h1c00_0102, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("adef_bus", fs_to_ds_bus, {1'b1, 32'h1c00_0102, 32'h0});
    check("adef_addr", 65'(inst_sram_addr), 65'h1c00_0106);
    step(0, 1, 0, 0, 0, 0);
    check("adef_next", 65'(fs_to_ds_bus[64:32]), 65'h1_1c00_0106);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // PC wraps at 32 bits.
    step(0, 1, 1, 32'hffff_fffc, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("wrap_addr", 65'(inst_sram_addr), 65'h0);
    step(0, 1, 0, 0, 0, 0);
    // Reset mid-stream.
    step(1, 1, 0, 0, 0, 0);
    check("mid_rst_en", 65'(inst_sram_en), 65'd0);
    check("mid_rst_valid", 65'(fs_to_ds_valid), 65'd0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("mid_rst_addr", 65'(inst_sram_addr), 65'h1c00_0000);
    step(0, 1, 0, 0, 0, 0);
    // Mixed traffic, checked by the model only.
    for (int i = 0; i < 80; i++) begin
      logic        ds, br, ex;
      logic [31:0] tgt, rpc;
      ds  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 7) == 0);
      ex  = ($urandom_range(0, 15) == 0);
      tgt = {16'h1c00, 14'($urandom()), ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00};
      rpc = {16'h1c00, 14'($urandom()), 2'b00};
      step(0, ds, br, tgt, ex, rpc);
    end
    step(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
